// File: rtl/wb_cmd_master.sv
// Command-word Wishbone classic master: one {op,payload} in, one bus cycle,
// one {code,data} out. Supports address load, auto-increment and timeout.
module wb_cmd_master #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BYTE_ADDR = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_stb,
  input  logic [DW+1:0]   cmd_word,
  output logic            cmd_busy,
  output logic            rsp_stb,
  output logic [DW+1:0]   rsp_word,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  localparam int MW   = (AW > DW) ? AW : DW;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [AW-1:0] STEP =
    (BYTE_ADDR != 0) ? AW'(DW / 8) : AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            rsp_stb_q, rsp_stb_d;
  logic [DW+1:0]   rsp_q, rsp_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            inc_q, inc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      op;
  logic [DW-1:0]   payload;
  logic            accept;
  logic [AW-1:0]   ld_addr;

  assign op       = cmd_word[DW+1:DW];
  assign payload  = cmd_word[DW-1:0];
  assign accept   = cmd_stb && !busy_q && (state_q == IDLE);
  // Widen through MW so both AW>DW and AW<DW zero-extend/truncate cleanly
  assign ld_addr  = AW'(MW'(payload));

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    rsp_stb_d = 1'b0;
    rsp_d     = rsp_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    inc_d     = inc_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
          unique case (op)
            2'b00, 2'b01: begin
              state_d = BUS;
              cyc_d   = 1'b1;
              we_d    = op[0];
              cnt_d   = '0;
              if (op[0]) wdata_d = payload;
            end
            2'b10: begin
              state_d = RESP;
              addr_d  = ld_addr;
              rsp_d   = {2'b10, DW'(MW'(ld_addr))};
            end
            default: begin
              state_d = RESP;
              inc_d   = payload[0];
              rsp_d   = {2'b10, DW'(MW'(addr_q))};
            end
          endcase
        end
      end
      BUS: begin
        if (i_wb_err) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          rsp_d   = {2'b11, {DW{1'b0}}};
        end else if (i_wb_ack) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          rsp_d   = we_q ? {2'b01, {DW{1'b0}}}
                         : {2'b00, i_wb_data};
          if (inc_q) addr_d = addr_q + STEP;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TLIM)) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          rsp_d   = {2'b11, DW'(1)};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        rsp_stb_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      rsp_stb_q <= 1'b0;
      rsp_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      inc_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      rsp_stb_q <= rsp_stb_d;
      rsp_q     <= rsp_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      inc_q     <= inc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cmd_busy  = busy_q;
  assign rsp_stb   = rsp_stb_q;
  assign rsp_word  = rsp_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = cyc_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = wdata_q;
  assign o_wb_sel  = '1;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed cases plus random commands
// against a transaction-level model of address/flag/response rules.
module tb_wb_cmd_master;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;
  localparam int TMO    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        cmd_busy;
  logic        rsp_stb;
  logic [33:0] rsp_word;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] addr_m;
  bit          inc_m;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .AW(32), .DW(32), .BYTE_ADDR(1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_stb(cmd_stb), .cmd_word(cmd_word), .cmd_busy(cmd_busy),
    .rsp_stb(rsp_stb), .rsp_word(rsp_word),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cyc"},  64'(o_wb_cyc),  64'(0));
    check({tag, "_stb"},  64'(o_wb_stb),  64'(0));
    check({tag, "_we"},   64'(o_wb_we),   64'(0));
    check({tag, "_busy"}, 64'(cmd_busy),  64'(0));
    check({tag, "_rstb"}, 64'(rsp_stb),   64'(0));
    check({tag, "_rsp"},  64'(rsp_word),  64'(0));
    check({tag, "_addr"}, 64'(o_wb_addr), 64'(0));
    check({tag, "_data"}, 64'(o_wb_data), 64'(0));
    check({tag, "_sel"},  64'(o_wb_sel),  64'(4'hF));
  endtask

  // One command end-to-end; slave answers on bus cycle waits+1 per mode
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] pl,
                         input int mode, input int waits,
                         input logic [31:0] rd, input bit hold);
    logic [1:0]  ecode;
    logic [31:0] edata;
    logic [31:0] eaddr;
    int          elat;
    int          ecyc;
    int          ncyc;
    bit          got;
    eaddr = addr_m;
    if (op == 2'b10) begin
      addr_m = pl;
      ecode = 2'b10; edata = pl; elat = 2; ecyc = 0;
    end else if (op == 2'b11) begin
      inc_m = pl[0];
      ecode = 2'b10; edata = addr_m; elat = 2; ecyc = 0;
    end else if (mode == M_NONE) begin
      ecode = 2'b11; edata = 32'd1; elat = TMO + 2; ecyc = TMO;
    end else if (mode == M_ACK) begin
      ecode = op; edata = op[0] ? 32'd0 : rd;
      elat = waits + 3; ecyc = waits + 1;
      if (inc_m) addr_m = addr_m + 32'd4;
    end else begin
      ecode = 2'b11; edata = 32'd0;
      elat = waits + 3; ecyc = waits + 1;
    end
    @(negedge clk);
    cmd_stb  = 1'b1;
    cmd_word = {op, pl};
    got  = 1'b0;
    ncyc = 0;
    for (int k = 1; k <= 16 && !got; k++) begin
      @(negedge clk);
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      if (!hold) cmd_stb = 1'b0;
      if (k == 1) check("busy", 64'(cmd_busy), 64'(1));
      if (o_wb_cyc) begin
        ncyc++;
        check("addr", 64'(o_wb_addr), 64'(eaddr));
        check("we", 64'(o_wb_we), 64'(op[0]));
        check("stb", 64'(o_wb_stb), 64'(1));
        if (op[0]) check("wdata", 64'(o_wb_data), 64'(pl));
        if (mode != M_NONE && ncyc == waits + 1) begin
          i_wb_ack  = (mode != M_ERR);
          i_wb_err  = (mode != M_ACK);
          i_wb_data = rd;
        end
      end
      if (rsp_stb) begin
        got     = 1'b1;
        cmd_stb = 1'b0;
        check("latency", 64'(k), 64'(elat));
        check("rsp", 64'(rsp_word), 64'({ecode, edata}));
        check("ncyc", 64'(ncyc), 64'(ecyc));
        check("rsp_busy", 64'(cmd_busy), 64'(0));
      end
    end
    if (!got) check("rsp_seen", 64'(0), 64'(1));
    // Stray ack/err while idle must be ignored
    i_wb_ack = 1'b1;
    i_wb_err = $urandom_range(0, 1) == 1;
    @(negedge clk);
    check("late_rstb", 64'(rsp_stb), 64'(0));
    check("late_cyc", 64'(o_wb_cyc), 64'(0));
    check("late_busy", 64'(cmd_busy), 64'(0));
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] pl;
    int          r;
    reset     = 1'b1;
    cmd_stb   = 1'b0;
    cmd_word  = '0;
    i_wb_ack  = 1'b0;
    i_wb_err  = 1'b0;
    i_wb_data = '0;
    addr_m    = '0;
    inc_m     = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    run_cmd(2'b10, 32'h100, M_ACK, 0, 0, 0);
    run_cmd(2'b01, 32'hDEADBEEF, M_ACK, 0, 0, 0);

    run_cmd(2'b11, 32'h1, M_ACK, 0, 0, 0);
    run_cmd(2'b10, 32'hFFFFFFFC, M_ACK, 0, 0, 0);
    run_cmd(2'b00, 32'h0, M_ACK, 0, 32'hA, 0);
    run_cmd(2'b00, 32'h0, M_ACK, 1, 32'hB, 0);

    run_cmd(2'b00, 32'h0, M_BOTH, 0, 32'h77, 0);
    run_cmd(2'b00, 32'h0, M_ERR, 2, 32'h78, 0);
    run_cmd(2'b00, 32'h0, M_NONE, 0, 32'h79, 0);
    run_cmd(2'b01, 32'h1234, M_ACK, 3, 0, 0);

    run_cmd(2'b00, 32'h0, M_ACK, 1, 32'hC0FFEE, 1);
    run_cmd(2'b10, 32'h40, M_ACK, 0, 0, 1);

    // Reset while the slave is stalling a write
    run_cmd(2'b10, 32'h1230, M_ACK, 0, 0, 0);
    @(negedge clk);
    cmd_stb  = 1'b1;
    cmd_word = {2'b01, 32'h55AA55AA};
    repeat (2) @(negedge clk);
    cmd_stb = 1'b0;
    check("pre_rst_cyc", 64'(o_wb_cyc), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    reset  = 1'b0;
    addr_m = '0;
    inc_m  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rstb", 64'(rsp_stb), 64'(0));
    end
    run_cmd(2'b00, 32'h0, M_ACK, 0, 32'h5, 0);

    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      pl = $urandom;
      if (op == 2'b10 && $urandom_range(0, 3) == 0)
        pl = 32'hFFFFFFF0 | (pl & 32'hC);
      r = $urandom_range(0, 9);
      run_cmd(op, pl,
              (r < 6) ? M_ACK : (r == 6) ? M_ERR :
              (r == 7) ? M_BOTH : (r == 8) ? M_ACK : M_NONE,
              $urandom_range(0, 3), $urandom,
              $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
